mod_msg_scheduler: RTL and testbench
====================================

// Module: mod_msg_scheduler
// PURPOSE
//  SHA-256 message-schedule producer: the source side of the compressor's round-word stream.
//  Accepts one 512-bit block as 16 x 32-bit words over a valid/ready load port.
//  Emits W[0..63] with the round index, one round per accepted output beat.
//  Uses a 16-entry circular buffer; W[16..63] is expanded in place.
// PARAMETERS
//  WORD_W   32  word width; only 32 is supported
//  ROUNDS   64  rounds emitted per block; only 64 is supported
// PORTS
//  CLK        in   1   single clock, rising edge
//  RESET      in   1   asynchronous, active-low reset
//  LD_VALID   in   1   LD_WORD carries a valid block word
//  LD_READY   out  1   scheduler accepts a load word this cycle
//  LD_WORD    in   32  block word, big-endian order, word 0 first
//  W_VALID    out  1   W_OUT and I_OUT are valid
//  W_READY    in   1   consumer takes the current round this cycle
//  W_OUT      out  32  schedule word W[I_OUT]
//  I_OUT      out  6   round index 0..63
//  W_LAST     out  1   high with W_VALID when I_OUT==63
//  K_OUT      out  32  K[I_OUT]; present only with MSG_SCHED_K_ROM_EN
// BEHAVIOUR
//  States: LOAD, RUN.
//  Reset (RESET low, async): state=LOAD, cnt=0, LD_READY=1, W_VALID=0, I_OUT=0, W_OUT=0, W_LAST=0.
//  Buffer contents are not reset.
//  LOAD:
//   - LD_READY=1, W_VALID=0.
//   - On LD_VALID&&LD_READY: buf[cnt]<=LD_WORD, cnt<=cnt+1.
//   - The 16th accept (cnt==15) goes to RUN with cnt=0.
//  RUN:
//   - LD_READY=0, W_VALID=1, I_OUT=cnt. W_OUT is combinational from buf and cnt.
//   - Latency: round 0 is valid the cycle after the 16th load accept.
//   - t<16: W_OUT=buf[t].
//   - t>=16: W_OUT = s1(buf[(t-2)&15]) + buf[(t-7)&15] + s0(buf[(t-15)&15]) + buf[t&15], mod 2^32.
//   - s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10.
//  Round handshake:
//   - On W_VALID&&W_READY: for t>=16, buf[t&15]<=W_OUT; cnt<=cnt+1.
//   - W_READY low holds all outputs and the buffer stable; there is no limit on stall length.
//   - Accept at t==63 (W_LAST=1): state=LOAD, cnt=0. LD_READY rises the next cycle.
//   - No overlap between a block's rounds and the next block's load.
//  LD_VALID during RUN is ignored; LD_READY=0, so no word is lost.
//  cnt is 6-bit; the wrap 63->0 coincides with the return to LOAD.
//  Mid-operation reset (either state) aborts the block. The next block restarts at load word 0.
// CONFIGURATION
//  MSG_SCHED_K_ROM_EN defined:
//   - K_OUT port exists and carries K[I_OUT] from a 64-entry constant table.
//   - K_OUT is combinational and follows I_OUT, also while stalled.
//   - The compressor needs no separate K source.
//  Not defined: no K_OUT port and no K table; the round constant is supplied externally, indexed by I_OUT.
// STRUCTURE
//  Shared package sha256_pkg:
//   - constants SHA_WORD_W=32, SHA_ROUNDS=64, SHA_BLK_WORDS=16
//   - 64-entry K constant table
//   - functions sha_s0, sha_s1
//   - state enum {LOAD, RUN}
//  One sub-module: mod_sched_expand, the combinational 4-input expansion adder using sha_s0/sha_s1.
//  Buffer, counter and FSM stay in mod_msg_scheduler.
// TESTING
//  1. Reset low mid-RUN (t=20) -> next cycle W_VALID=0, LD_READY=1, I_OUT=0; a fresh 16-word load restarts at round 0.
//  2. Load all-zero block, W_READY=1 -> 64 beats, W_OUT=0 for all rounds, W_LAST only at I_OUT=63, then LD_READY=1.
//  3. Load W0=1, others 0 -> W[16]=0x00000001, W[17]=0x00000000, W[18]=0x0000A000.
//  4. Load W1=1, others 0 -> W[16]=0x02004000 (s0 check); W[0..15] echo the loaded words.
//  5. Load "Hello world!" block (W0=0x48656c6c, W1=0x6f20776f, W2=0x726c6421, W3=0x80000000, W15=0x00000060).
//     Toggle W_READY randomly -> W sequence matches the golden model; outputs stay stable while stalled.
//  6. Drive LD_VALID=1 throughout RUN -> no buffer corruption; load resumes only after W_LAST accept.
//     With MSG_SCHED_K_ROM_EN: K_OUT=0x428a2f98 at I_OUT=0 and 0xc67178f2 at I_OUT=63.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round constants, the K round-constant table,
// the small sigma functions and the scheduler state type.
package sha256_pkg;

  localparam int SHA_WORD_W    = 32;
  localparam int SHA_ROUNDS    = 64;
  localparam int SHA_BLK_WORDS = 16;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } sha_state_t;

  localparam logic [SHA_WORD_W-1:0] SHA_K [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [SHA_WORD_W-1:0] sha_rotr(input logic [SHA_WORD_W-1:0] x,
                                                     input int n);
    return (x >> n) | (x << (SHA_WORD_W - n));
  endfunction

  function automatic logic [SHA_WORD_W-1:0] sha_s0(input logic [SHA_WORD_W-1:0] x);
    return sha_rotr(x, 7) ^ sha_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [SHA_WORD_W-1:0] sha_s1(input logic [SHA_WORD_W-1:0] x);
    return sha_rotr(x, 17) ^ sha_rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/mod_sched_expand.sv
// Combinational message-expansion adder: s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module mod_sched_expand
  import sha256_pkg::*;
(
  input  logic [SHA_WORD_W-1:0] w_m2,
  input  logic [SHA_WORD_W-1:0] w_m7,
  input  logic [SHA_WORD_W-1:0] w_m15,
  input  logic [SHA_WORD_W-1:0] w_m16,
  output logic [SHA_WORD_W-1:0] w_new
);

  assign w_new = sha_s1(w_m2) + w_m7 + sha_s0(w_m15) + w_m16;

endmodule

// File: rtl/mod_msg_scheduler.sv
// SHA-256 message-schedule producer: loads 16 block words, then streams W[0..63].
// Optional K_OUT round-constant port is built when MSG_SCHED_K_ROM_EN is defined.
module mod_msg_scheduler
  import sha256_pkg::*;
#(
  parameter int WORD_W = SHA_WORD_W,
  parameter int ROUNDS = SHA_ROUNDS
)
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      LD_VALID,
  output logic                      LD_READY,
  input  logic [WORD_W-1:0]         LD_WORD,
  output logic                      W_VALID,
  input  logic                      W_READY,
  output logic [WORD_W-1:0]         W_OUT,
  output logic [$clog2(ROUNDS)-1:0] I_OUT,
`ifdef MSG_SCHED_K_ROM_EN
  output logic [WORD_W-1:0]         K_OUT,
`endif
  output logic                      W_LAST
);

  localparam int CNT_W = $clog2(ROUNDS);

  sha_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] mem [SHA_BLK_WORDS];
  logic              ld_acc, w_acc, cnt_last_ld, cnt_last_rnd, cnt_expand;
  logic [3:0]        slot, slot_m2, slot_m7, slot_m15;
  logic [WORD_W-1:0] w_exp, w_cur;

  assign ld_acc       = (state == LOAD) && LD_VALID;
  assign w_acc        = (state == RUN) && W_READY;
  assign cnt_last_ld  = (cnt == CNT_W'(SHA_BLK_WORDS - 1));
  assign cnt_last_rnd = (cnt == CNT_W'(ROUNDS - 1));
  assign cnt_expand   = (cnt >= CNT_W'(SHA_BLK_WORDS));

  // 4-bit slot arithmetic wraps mod 16, giving the circular-buffer taps.
  assign slot     = cnt[3:0];
  assign slot_m2  = slot - 4'd2;
  assign slot_m7  = slot - 4'd7;
  assign slot_m15 = slot - 4'd15;

  mod_sched_expand u_expand (
    .w_m2  (mem[slot_m2]),
    .w_m7  (mem[slot_m7]),
    .w_m15 (mem[slot_m15]),
    .w_m16 (mem[slot]),
    .w_new (w_exp)
  );

  assign w_cur = cnt_expand ? w_exp : mem[slot];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ld_acc && cnt_last_ld) state_nxt = RUN;
      RUN:     if (w_acc && cnt_last_rnd) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    LD_READY = 1'b0;
    W_VALID  = 1'b0;
    W_OUT    = '0;
    I_OUT    = '0;
    W_LAST   = 1'b0;
    if (state == RUN) begin
      W_VALID = 1'b1;
      W_OUT   = w_cur;
      I_OUT   = cnt;
      W_LAST  = cnt_last_rnd;
    end else begin
      LD_READY = 1'b1;
    end
  end

  // The 64-round counter wraps to 0 on the final accept, coinciding with LOAD.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (ld_acc) begin
      cnt <= cnt_last_ld ? '0 : cnt + 1'b1;
    end else if (w_acc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expanded words overwrite the W[t-16] slot they were derived from.
  always_ff @(posedge CLK) begin
    if (ld_acc) begin
      mem[slot] <= LD_WORD;
    end else if (w_acc && cnt_expand) begin
      mem[slot] <= w_exp;
    end
  end

`ifdef MSG_SCHED_K_ROM_EN
  assign K_OUT = SHA_K[I_OUT];
`endif

endmodule

// File: tb/tb_mod_msg_scheduler.sv
// Bench for mod_msg_scheduler: table vectors on one-hot blocks plus randomized
// stall/load-noise runs checked against an array-based SHA-256 schedule model.
module tb_mod_msg_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        LD_VALID = 1'b0;
  logic        LD_READY;
  logic [31:0] LD_WORD = '0;
  logic        W_VALID;
  logic        W_READY = 1'b0;
  logic [31:0] W_OUT;
  logic [5:0]  I_OUT;
  logic        W_LAST;
`ifdef MSG_SCHED_K_ROM_EN
  logic [31:0] K_OUT;
`endif

  mod_msg_scheduler dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .LD_WORD  (LD_WORD),
    .W_VALID  (W_VALID),
    .W_READY  (W_READY),
    .W_OUT    (W_OUT),
    .I_OUT    (I_OUT),
`ifdef MSG_SCHED_K_ROM_EN
    .K_OUT    (K_OUT),
`endif
    .W_LAST   (W_LAST)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] blk_in [16];
  logic [31:0] exp_w  [64];
  logic [31:0] got_w  [64];

  typedef struct {
    string       name;
    int          one_pos;
    int          round;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ref_rotr(x, 7) ^ ref_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ref_rotr(x, 17) ^ ref_rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk_in[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic load_block();
    int i = 0;
    int guard = 0;
    while (i < 16 && guard < 200) begin
      @(negedge CLK);
      guard++;
      LD_VALID = 1'b1;
      LD_WORD  = blk_in[i];
      if (LD_READY) i++;
    end
    if (i < 16) chk("load_timeout", 32'(i), 32'd16);
    @(negedge CLK);
    LD_VALID = 1'b0;
  endtask

  // stall: percent of cycles with W_READY low; ld_hold: drive junk loads during RUN.
  task automatic run_block(input int stall, input bit ld_hold, input int stop_at);
    int          idx = 0;
    int          guard = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] pw = '0;
    logic [5:0]  pi = '0;
    while (idx < stop_at && guard < 3000) begin
      guard++;
      if (ld_hold) begin
        LD_VALID = 1'b1;
        LD_WORD  = $urandom;
      end
      if (prev_stall) begin
        chk("stall_w_out", W_OUT, pw);
        chk("stall_i_out", 32'(I_OUT), 32'(pi));
      end
      W_READY = (stall > 0) ? 1'($urandom_range(0, 99) >= stall) : 1'b1;
      if (W_VALID && W_READY) begin
        chk($sformatf("w_out[%0d]", idx), W_OUT, exp_w[idx]);
        chk($sformatf("i_out[%0d]", idx), 32'(I_OUT), 32'(idx));
        chk($sformatf("w_last[%0d]", idx), 32'(W_LAST), 32'(idx == 63));
        chk($sformatf("ld_ready_run[%0d]", idx), 32'(LD_READY), 32'd0);
`ifdef MSG_SCHED_K_ROM_EN
        if (idx == 0)  chk("k_out[0]", K_OUT, 32'h428a2f98);
        if (idx == 63) chk("k_out[63]", K_OUT, 32'hc67178f2);
`endif
        got_w[idx] = W_OUT;
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = W_VALID;
        pw = W_OUT;
        pi = I_OUT;
      end
      @(negedge CLK);
    end
    W_READY = 1'b0;
    if (idx < stop_at) chk("run_timeout", 32'(idx), 32'(stop_at));
    if (stop_at == 64) begin
      chk("ld_ready_after_last", 32'(LD_READY), 32'd1);
      chk("w_valid_after_last", 32'(W_VALID), 32'd0);
      LD_VALID = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_w_valid"}, 32'(W_VALID), 32'd0);
    chk({tag, "_ld_ready"}, 32'(LD_READY), 32'd1);
    chk({tag, "_i_out"}, 32'(I_OUT), 32'd0);
    chk({tag, "_w_out"}, W_OUT, 32'd0);
    chk({tag, "_w_last"}, 32'(W_LAST), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"zero_w0",   -1,  0, 32'h00000000};
    tbl[1] = '{"zero_w40",  -1, 40, 32'h00000000};
    tbl[2] = '{"zero_w63",  -1, 63, 32'h00000000};
    tbl[3] = '{"w0one_w16",  0, 16, 32'h00000001};
    tbl[4] = '{"w0one_w17",  0, 17, 32'h00000000};
    tbl[5] = '{"w0one_w18",  0, 18, 32'h0000A000};
    tbl[6] = '{"w1one_w16",  1, 16, 32'h02004000};
    tbl[7] = '{"w1one_w1",   1,  1, 32'h00000001};

    repeat (2) @(negedge CLK);
    check_idle("reset");
    RESET = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < 16; j++) blk_in[j] = (j == tbl[v].one_pos) ? 32'd1 : 32'd0;
      build_model();
      load_block();
      run_block(0, 1'b0, 64);
      chk(tbl[v].name, got_w[tbl[v].round], tbl[v].exp);
    end

    for (int j = 0; j < 16; j++) blk_in[j] = 32'd0;
    blk_in[0]  = 32'h48656c6c;
    blk_in[1]  = 32'h6f20776f;
    blk_in[2]  = 32'h726c6421;
    blk_in[3]  = 32'h80000000;
    blk_in[15] = 32'h00000060;
    build_model();
    load_block();
    run_block(50, 1'b0, 64);

    for (int j = 0; j < 16; j++) blk_in[j] = $urandom;
    build_model();
    load_block();
    run_block(30, 1'b1, 64);

    for (int j = 0; j < 16; j++) blk_in[j] = $urandom;
    build_model();
    load_block();
    run_block(0, 1'b0, 64);

    for (int j = 0; j < 16; j++) blk_in[j] = $urandom;
    build_model();
    load_block();
    run_block(20, 1'b0, 20);
    RESET = 1'b0;
    #1;
    check_idle("midrun_reset");
    @(negedge CLK);
    RESET = 1'b1;
    for (int j = 0; j < 16; j++) blk_in[j] = $urandom;
    build_model();
    load_block();
    run_block(0, 1'b0, 64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
